// File: rtl/banco_regs_pkg.sv
// rtl/banco_regs_pkg.sv - shared state enum and address-width helper for the register bank
package banco_regs_pkg;

  // Clear-sequencer states: LIMPA zeroes the array, OPERA serves reads and writes
  typedef enum logic {
    LIMPA = 1'b0,
    OPERA = 1'b1
  } estado_t;

  // Address width for n registers; never below one bit
  function automatic int largura_end(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sequenciador_limpeza.sv
// rtl/sequenciador_limpeza.sv - clear FSM walking cnt over every register after reset
module sequenciador_limpeza
  import banco_regs_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int END_W    = largura_end(NUM_REGS)
) (
  input  logic             clock,
  input  logic             reset,
  output logic [END_W-1:0] cnt,
  output logic             limpando,
  output logic             pronto
);

  localparam logic [END_W-1:0] ULTIMO = END_W'(NUM_REGS - 1);

  estado_t          r_estado;
  logic [END_W-1:0] r_cnt;
  logic             r_limpando;
  logic             r_pronto;

  // Single FSM: step cnt once per cycle in LIMPA, then park in OPERA until the next reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= LIMPA;
      r_cnt      <= '0;
      r_limpando <= 1'b1;
      r_pronto   <= 1'b0;
    end else begin
      case (r_estado)
        LIMPA: begin
          if (r_cnt == ULTIMO) begin
            r_estado   <= OPERA;
            r_cnt      <= '0;
            r_limpando <= 1'b0;
            r_pronto   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + END_W'(1);
          end
        end
        OPERA: begin
          r_limpando <= 1'b0;
          r_pronto   <= 1'b1;
        end
        default: begin
          r_estado <= LIMPA;
        end
      endcase
    end
  end

  assign cnt      = r_cnt;
  assign limpando = r_limpando;
  assign pronto   = r_pronto;

endmodule

// File: rtl/banco_registradores_param.sv
// rtl/banco_registradores_param.sv - two-read one-write register bank with self-clearing and write-first reads
module banco_registradores_param
  import banco_regs_pkg::*;
#(
  parameter  int LARGURA   = 16,
  parameter  int NUM_REGS  = 32,
  parameter  int ZERO_FIXO = 1,
  localparam int END_W     = largura_end(NUM_REGS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               RegWrite,
  input  logic [END_W-1:0]   registrador1,
  input  logic [END_W-1:0]   registrador2,
  input  logic [END_W-1:0]   registrador3,
  input  logic [LARGURA-1:0] dado_escrita,
  output logic [LARGURA-1:0] dado1,
  output logic [LARGURA-1:0] dado2,
  output logic               pronto,
  output logic               erro_escrita
);

  // One past the last valid address, one bit wider so NUM_REGS itself fits
  localparam logic [END_W:0] LIMITE = (END_W + 1)'(NUM_REGS);

  logic [LARGURA-1:0] r_mem [NUM_REGS];
  logic [LARGURA-1:0] r_dado1;
  logic [LARGURA-1:0] r_dado2;
  logic               r_erro;

  logic [END_W-1:0]   w_cnt;
  logic               w_limpando;
  logic               w_pronto;
  logic               w_valido3;
  logic               w_zero3;
  logic               w_wr_ok;
  logic [LARGURA-1:0] w_rd1;
  logic [LARGURA-1:0] w_rd2;

  sequenciador_limpeza #(
    .NUM_REGS (NUM_REGS),
    .END_W    (END_W)
  ) u_seq (
    .clock    (clock),
    .reset    (reset),
    .cnt      (w_cnt),
    .limpando (w_limpando),
    .pronto   (w_pronto)
  );

  assign w_valido3 = ({1'b0, registrador3} < LIMITE);
  assign w_zero3   = (ZERO_FIXO != 0) && (registrador3 == '0);
  assign w_wr_ok   = !reset && !w_limpando && RegWrite && w_valido3 && !w_zero3;

  // Read mux: out-of-range and pinned-zero addresses give 0, a same-cycle write wins over the array
  function automatic logic [LARGURA-1:0] ler(
    input logic [END_W-1:0]   end_rd,
    input logic [LARGURA-1:0] valor_mem
  );
    if ({1'b0, end_rd} >= LIMITE)                   return '0;
    else if ((ZERO_FIXO != 0) && (end_rd == '0))    return '0;
    else if (w_wr_ok && (end_rd == registrador3))   return dado_escrita;
    else                                            return valor_mem;
  endfunction

  // Combinational read data for both ports, registered below
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    w_rd1 = ler(registrador1, r_mem[registrador1]);
    w_rd2 = ler(registrador2, r_mem[registrador2]);
  end

  // Array update: no reset here, contents are zeroed by the clear walk instead
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_limpando) begin
        r_mem[w_cnt] <= '0;
      end else if (w_wr_ok) begin
        r_mem[registrador3] <= dado_escrita;
      end
    end
  end

  // Registered read ports, held at zero while reset or clearing
  always_ff @(posedge clock) begin
    if (reset || w_limpando) begin
      r_dado1 <= '0;
      r_dado2 <= '0;
    end else begin
      r_dado1 <= w_rd1;
      r_dado2 <= w_rd2;
    end
  end

  // Rejected-write flag: a write during clearing or to a nonexistent register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_erro <= 1'b0;
    end else begin
      r_erro <= RegWrite && (w_limpando || !w_valido3);
    end
  end

  assign dado1        = r_dado1;
  assign dado2        = r_dado2;
  assign pronto       = w_pronto;
  assign erro_escrita = r_erro;

endmodule

// File: tb/tb_banco_registradores_param.sv
// tb/tb_banco_registradores_param.sv - directed bench with a behavioural bank model for 32- and 20-register instances
module tb_banco_registradores_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        we;
  logic [4:0]  a1, a2, a3;
  logic [15:0] d;
  logic [15:0] d1a, d2a, d1b, d2b;
  logic        pa, pb, ea, eb;
  logic        chk_en;

  int checks   = 0;
  int failures = 0;

  banco_registradores_param #(.LARGURA(16), .NUM_REGS(32), .ZERO_FIXO(1)) dut_a (
    .clock(clk), .reset(reset), .RegWrite(we),
    .registrador1(a1), .registrador2(a2), .registrador3(a3),
    .dado_escrita(d), .dado1(d1a), .dado2(d2a), .pronto(pa), .erro_escrita(ea)
  );

  banco_registradores_param #(.LARGURA(16), .NUM_REGS(20), .ZERO_FIXO(1)) dut_b (
    .clock(clk), .reset(reset), .RegWrite(we),
    .registrador1(a1), .registrador2(a2), .registrador3(a3),
    .dado_escrita(d), .dado1(d1b), .dado2(d2b), .pronto(pb), .erro_escrita(eb)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: clear progress counted in cycles since reset, plain array of contents
  int          nreg [2] = '{32, 20};
  logic [15:0] mem  [2][32];
  int          since [2];
  logic [15:0] x1 [2];
  logic [15:0] x2 [2];
  logic        xp [2];
  logic        xe [2];

  function automatic logic [15:0] rd(input int k, input int a);
    if (a >= nreg[k] || a == 0) return 16'h0000;
    return mem[k][a];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        since[k] = 0;
        x1[k] = 16'h0; x2[k] = 16'h0; xp[k] = 1'b0; xe[k] = 1'b0;
      end else if (since[k] < nreg[k]) begin
        mem[k][since[k]] = 16'h0;
        since[k]++;
        x1[k] = 16'h0; x2[k] = 16'h0;
        xe[k] = we;
        xp[k] = (since[k] >= nreg[k]);
      end else begin
        xe[k] = we && (int'(a3) >= nreg[k]);
        if (we && int'(a3) < nreg[k] && a3 != 0) mem[k][a3] = d;
        x1[k] = rd(k, int'(a1));
        x2[k] = rd(k, int'(a2));
        xp[k] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_dado1_a", d1a, x1[0]);
      check("model_dado2_a", d2a, x2[0]);
      check("model_pronto_a", pa, xp[0]);
      check("model_erro_a", ea, xe[0]);
      check("model_dado1_b", d1b, x1[1]);
      check("model_dado2_b", d2b, x2[1]);
      check("model_pronto_b", pb, xp[1]);
      check("model_erro_b", eb, xe[1]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int fa, fb;

  initial begin
    chk_en = 1'b0;
    reset = 1'b1; we = 1'b1; a1 = 5'd0; a2 = 5'd0; a3 = 5'd5; d = 16'h5555;
    repeat (3) begin
      cyc();
      chk_en = 1'b1;
      check("rst_pronto", pa, 0);
      check("rst_dado1", d1a, 0);
      check("rst_dado2", d2a, 0);
      check("rst_erro", ea, 0);
    end

    reset = 1'b0; we = 1'b0;
    fa = 0; fb = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (fa == 0 && pa === 1'b1) fa = i;
      if (fb == 0 && pb === 1'b1) fb = i;
    end
    check("pronto_lat_a", fa, 32);
    check("pronto_lat_b", fb, 20);

    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(31 - i);
      cyc();
      check("clr_rd1", d1a, 0);
      check("clr_rd2", d2a, 0);
    end

    we = 1'b1; a3 = 5'd5; d = 16'hBEEF; a1 = 5'd5;
    cyc();
    check("fwd_beef", d1a, 16'hBEEF);
    we = 1'b0;
    cyc();
    check("hold_beef", d1a, 16'hBEEF);
    check("beef_erro", ea, 0);

    we = 1'b1; a3 = 5'd0; d = 16'h1234; a1 = 5'd0; a2 = 5'd0;
    cyc();
    check("r0_fwd", d1a, 0);
    check("r0_erro", ea, 0);
    we = 1'b0;
    cyc();
    check("r0_rd1", d1a, 0);
    check("r0_rd2", d2a, 0);

    we = 1'b1; a3 = 5'd25; d = 16'h00AA; a1 = 5'd25;
    cyc();
    check("oob_erro_b", eb, 1);
    check("oob_erro_a", ea, 0);
    check("oob_fwd_b", d1b, 0);
    check("fwd_a25", d1a, 16'h00AA);
    we = 1'b0;
    cyc();
    check("oob_pulse_b", eb, 0);
    check("oob_rd_b", d1b, 0);
    check("rd_a25", d1a, 16'h00AA);
    for (int i = 0; i < 20; i++) begin
      a1 = 5'(i); a2 = 5'(19 - i);
      cyc();
      if (i == 5) check("b_r5_beef", d1b, 16'hBEEF);
    end

    for (int i = 1; i < 32; i++) begin
      we = 1'b1; a3 = 5'(i); d = 16'(i * 16'h0101);
      cyc();
    end
    we = 1'b0; a1 = 5'd31; a2 = 5'd17;
    cyc();
    check("fill31", d1a, 16'h1F1F);
    check("fill17", d2a, 16'h1111);

    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (10) cyc();
    reset = 1'b1;
    cyc();
    check("midclr_pronto", pa, 0);
    reset = 1'b0;
    fa = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        we = 1'b1; a3 = 5'd3; d = 16'h0077;
      end
      cyc();
      if (i == 5) begin
        check("limpa_erro", ea, 1);
        we = 1'b0;
      end
      if (fa == 0 && pa === 1'b1) fa = i;
    end
    check("restart_lat", fa, 32);
    a1 = 5'd31; a2 = 5'd3;
    cyc();
    check("r31_cleared", d1a, 0);
    check("r3_cleared", d2a, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/banco_registradores_param.md
BANCO_REGISTRADORES_PARAM -- requirements
Module: banco_registradores_param

Interface
REQ-001 Parameter LARGURA, default 16: data width in bits of every register.
REQ-002 Parameter NUM_REGS, default 32: number of registers, range 2..256, not necessarily a power of two.
REQ-003 Parameter ZERO_FIXO, default 1: when 1, register 0 reads as zero and ignores writes.
REQ-004 Derived constant END_W = clog2(NUM_REGS) SHALL size all address ports.
REQ-005 clock  input  1  single clock; all state SHALL update on its rising edge only.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 RegWrite  input  1  write enable for the current cycle.
REQ-008 registrador1  input  END_W  read address, port 1.
REQ-009 registrador2  input  END_W  read address, port 2.
REQ-010 registrador3  input  END_W  write address.
REQ-011 dado_escrita  input  LARGURA  write data.
REQ-012 dado1  output  LARGURA  registered read data, port 1.
REQ-013 dado2  output  LARGURA  registered read data, port 2.
REQ-014 pronto  output  1  high when the clear sequence is done and the block accepts reads and writes.
REQ-015 erro_escrita  output  1  one-cycle pulse flagging a rejected write.

Function
REQ-016 The FSM SHALL have two states, LIMPA and OPERA, plus a clear counter cnt of width END_W.
REQ-017 In LIMPA, with reset low, each cycle SHALL write zero to reg[cnt] and increment cnt.
REQ-018 After the cycle that clears reg[NUM_REGS-1], the FSM SHALL go to OPERA, and pronto SHALL read 1 from the next cycle.
REQ-019 pronto SHALL rise exactly NUM_REGS cycles after the first rising edge with reset low.
REQ-020 In OPERA, when RegWrite=1 and the address is valid, reg[registrador3] SHALL take dado_escrita at the rising edge.
REQ-021 Read latency SHALL be one cycle: dado1 and dado2 take the values addressed by registrador1 and registrador2 at the edge.
REQ-022 Reads SHALL be write-first: when a read address equals registrador3 in a valid write cycle, dado_escrita SHALL be returned in that same cycle.
REQ-023 With ZERO_FIXO=1, reads of address 0 SHALL return 0, writes to address 0 SHALL be dropped silently, and no forwarding SHALL occur for address 0.
REQ-024 An address >= NUM_REGS SHALL read as 0, and a write to it SHALL be dropped with erro_escrita=1 the next cycle.
REQ-025 RegWrite=1 while in LIMPA SHALL be dropped with erro_escrita=1 the next cycle.
REQ-026 In LIMPA, dado1 and dado2 SHALL stay at 0.
REQ-027 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.

Reset
REQ-028 While reset=1, the block SHALL hold: state=LIMPA, cnt=0, dado1=0, dado2=0, pronto=0, erro_escrita=0.
REQ-029 Register array contents SHALL not be defined by reset itself; they SHALL be zeroed only by the LIMPA sequence.
REQ-030 Reset asserted mid-clear or in OPERA SHALL restart the clear from cnt=0 and drop any write in that cycle.

Structure
REQ-031 Shared package banco_regs_pkg SHALL hold the state enum (LIMPA, OPERA) and the clog2-based address-width function.
REQ-032 The clear FSM and counter SHALL be one sub-module, sequenciador_limpeza, with outputs cnt, limpando and pronto.
REQ-033 The storage array, forwarding and read registers SHALL stay in the top module.

Verification (LARGURA=16, NUM_REGS=32, ZERO_FIXO=1 unless noted)
REQ-034 Reset 3 cycles, then release -> pronto=0 for 32 cycles and 1 on cycle 33; all 32 registers then read 0x0000.
REQ-035 Write 0xBEEF to r5 while reading registrador1=5 in the same cycle -> dado1=0xBEEF next cycle; r5 still reads 0xBEEF after.
REQ-036 Write 0x1234 to r0, then read r0 on both ports -> dado1=dado2=0x0000, erro_escrita=0.
REQ-037 NUM_REGS=20: write 0x00AA to address 25 -> erro_escrita pulses once; reading address 25 gives 0x0000; r0..r19 unchanged.
REQ-038 Fill r1..r31 with index*0x0101, assert reset at clear cycle 10, release -> pronto rises 32 cycles after release; r31 reads 0x0000; a write attempted during LIMPA gives an erro_escrita pulse.
